// File: rtl/fifo_rd_packer.sv
// Show-ahead FIFO read-side packer: pops WIDTH-bit words and emits RATIO-word beats on a valid/ready stream.
// Optional idle-timeout partial flush is enabled by defining FIFO_RD_PACK_FLUSH_TIMEOUT_EN.
module fifo_rd_packer #(
  parameter int WIDTH   = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fifo_empty,
  input  logic [WIDTH-1:0]           fifo_dout,
  output logic                       fifo_rd_en,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH*RATIO-1:0]     m_data,
  output logic [$clog2(RATIO):0]     m_words
);

  localparam int CW = $clog2(RATIO);
  localparam int MW = CW + 1;
  localparam int AW = (RATIO - 1) * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  if (RATIO < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("fifo_rd_packer: RATIO must be >= 2 and TIMEOUT >= 1");
  end

  logic [AW-1:0]          acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   m_valid_q, m_valid_d;
  logic [WIDTH*RATIO-1:0] m_data_q, m_data_d;
  logic [MW-1:0]          m_words_q, m_words_d;
  logic                   slot_free;
  logic                   pop;

`ifdef FIFO_RD_PACK_FLUSH_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;
`endif

  always_comb begin
    slot_free  = !m_valid_q || m_ready;
    pop        = rst_n && !fifo_empty && (cnt_q != LAST || slot_free);
    fifo_rd_en = pop;

    acc_d     = acc_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    m_words_d = m_words_q;

    if (pop) begin
      if (cnt_q == LAST) begin
        m_data_d  = {fifo_dout, acc_q};
        m_words_d = MW'(RATIO);
        m_valid_d = 1'b1;
        cnt_d     = '0;
        acc_d     = '0;
      end else begin
        acc_d[cnt_q*WIDTH +: WIDTH] = fifo_dout;
        cnt_d = cnt_q + 1'b1;
      end
    end

`ifdef FIFO_RD_PACK_FLUSH_TIMEOUT_EN
    // The idle counter saturates so a flush blocked by backpressure fires on the first free slot.
    idle_d = idle_q;
    if (pop || cnt_q == '0) begin
      idle_d = '0;
    end else begin
      if (idle_q != IW'(TIMEOUT)) idle_d = idle_q + 1'b1;
      if (idle_q >= IW'(TIMEOUT - 1) && slot_free) begin
        m_data_d  = {{WIDTH{1'b0}}, acc_q};
        m_words_d = MW'(cnt_q);
        m_valid_d = 1'b1;
        cnt_d     = '0;
        acc_d     = '0;
        idle_d    = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_words_q <= '0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_words_q <= m_words_d;
    end
  end

`ifdef FIFO_RD_PACK_FLUSH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`endif

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_words = m_words_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: directed FIFO contents, expected beats queued, monitor compares on transfer.
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [2:0]  m_words;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  words;
  } beat_t;

  beat_t      sb_q[$];
  beat_t      mon_exp;
  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         pop_count = 0;
  bit         pop_pending = 1'b0;
  bit         hold_empty = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // Show-ahead FIFO model: head word is combinational, pop lands on the edge where rd_en was high.
  assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);
  assign fifo_dout  = mem[rd_ptr[7:0]];

  always @(negedge clk) pop_pending <= fifo_rd_en;

  always @(posedge clk) begin
    if (pop_pending && rst_n) begin
      rd_ptr    <= rd_ptr + 1;
      pop_count <= pop_count + 1;
    end
  end

  fifo_rd_packer #(.WIDTH(8), .RATIO(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_words    (m_words)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expectBeat(input logic [31:0] d, input logic [2:0] w);
    sb_q.push_back('{data: d, words: w});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: a beat transfers on the next edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    if (fifo_empty) checkOutput("rd_en_while_empty", {31'b0, fifo_rd_en}, 32'h0);
    if (rst_n && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got data 0x%0h words %0d, none expected", m_data, m_words);
      end else begin
        mon_exp = sb_q.pop_front();
        checkOutput("beat_data", m_data, mon_exp.data);
        checkOutput("beat_words", {29'b0, m_words}, {29'b0, mon_exp.words});
      end
    end
  end

  initial begin
    int base;
    int seen;

    // Reset values, with the FIFO already holding data.
    expectBeat(32'h44332211, 3'd4);
    expectBeat(32'h88776655, 3'd4);
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i * 8'h11));
    tick(2);
    checkOutput("reset_m_valid", {31'b0, m_valid}, 32'h0);
    checkOutput("reset_m_data", m_data, 32'h0);
    checkOutput("reset_m_words", {29'b0, m_words}, 32'h0);
    checkOutput("reset_rd_en", {31'b0, fifo_rd_en}, 32'h0);

    // Streaming: eight consecutive pops, valid visible right after the 4th pop edge.
    m_ready = 1'b1;
    rst_n   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stream_rd_en_%0d", i), {31'b0, fifo_rd_en}, 32'h1);
      checkOutput($sformatf("stream_valid_%0d", i), {31'b0, m_valid}, (i == 4) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    checkOutput("stream_valid_8", {31'b0, m_valid}, 32'h1);
    checkOutput("stream_rd_en_8", {31'b0, fifo_rd_en}, 32'h0);
    tick(2);
    checkOutput("stream_pops", pop_count, 32'd8);

    // Backpressure: beat held, three more pops, then stall with data waiting.
    m_ready = 1'b0;
    base = pop_count;
    expectBeat(32'h04030201, 3'd4);
    expectBeat(32'h08070605, 3'd4);
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
    tick(12);
    checkOutput("bp_pops", pop_count - base, 32'd7);
    checkOutput("bp_rd_en", {31'b0, fifo_rd_en}, 32'h0);
    checkOutput("bp_fifo_nonempty", {31'b0, fifo_empty}, 32'h0);
    checkOutput("bp_valid", {31'b0, m_valid}, 32'h1);
    checkOutput("bp_held_data", m_data, 32'h04030201);
    checkOutput("bp_held_words", {29'b0, m_words}, 32'd4);
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_rd_en", {31'b0, fifo_rd_en}, 32'h1);
    tick(1);
    m_ready = 1'b0;
    checkOutput("bp_b2b_valid", {31'b0, m_valid}, 32'h1);
    checkOutput("bp_b2b_data", m_data, 32'h08070605);
    checkOutput("bp_b2b_pops", pop_count - base, 32'd8);
    m_ready = 1'b1;
    tick(2);

    // FIFO empty flag toggling every cycle.
    base = pop_count;
    hold_empty = 1'b1;
    expectBeat(32'hA3A2A1A0, 3'd4);
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'hA0 + i));
    for (int i = 0; i < 12; i++) begin
      tick(1);
      hold_empty = ~hold_empty;
    end
    hold_empty = 1'b0;
    tick(3);
    checkOutput("toggle_pops", pop_count - base, 32'd4);

    // Asynchronous reset with a pending beat and a partial accumulator.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(8'(8'hD0 + i));
    tick(8);
    checkOutput("prereset_valid", {31'b0, m_valid}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", {31'b0, m_valid}, 32'h0);
    checkOutput("async_reset_data", m_data, 32'h0);
    tick(2);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    base = pop_count;
    expectBeat(32'hB3B2B1B0, 3'd4);
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'hB0 + i));
    tick(6);
    checkOutput("post_reset_pops", pop_count - base, 32'd4);

`ifdef FIFO_RD_PACK_FLUSH_TIMEOUT_EN
    // Timeout flush of a two-word partial beat after 16 idle cycles.
    expectBeat(32'h0000C2C1, 3'd2);
    applyStimulus(8'hC1);
    applyStimulus(8'hC2);
    tick(17);
    checkOutput("flush_early_valid", {31'b0, m_valid}, 32'h0);
    tick(1);
    checkOutput("flush_valid", {31'b0, m_valid}, 32'h1);
    checkOutput("flush_data", m_data, 32'h0000C2C1);
    checkOutput("flush_words", {29'b0, m_words}, 32'd2);
    tick(2);
    // A word arriving in the 16th idle cycle wins over the flush.
    expectBeat(32'hE4E3E2E1, 3'd4);
    applyStimulus(8'hE1);
    applyStimulus(8'hE2);
    tick(17);
    applyStimulus(8'hE3);
    tick(1);
    checkOutput("noflush_valid", {31'b0, m_valid}, 32'h0);
    applyStimulus(8'hE4);
    tick(3);
`else
    // Without the timeout a partial beat stays in the accumulator.
    applyStimulus(8'hC1);
    applyStimulus(8'hC2);
    tick(2);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (m_valid) seen++;
    end
    checkOutput("no_flush_cycles_valid", seen, 32'd0);
    expectBeat(32'hC4C3C2C1, 3'd4);
    applyStimulus(8'hC3);
    applyStimulus(8'hC4);
    tick(4);
`endif

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick(1);
    checkOutput("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
